// File: rtl/pong_video_renderer_pkg.sv
// Shared timing defaults, object geometry and palette for the pong VGA renderer.
package pong_video_renderer_pkg;

  localparam int unsigned HVisibleDef = 640;
  localparam int unsigned HFrontDef   = 16;
  localparam int unsigned HSyncDef    = 96;
  localparam int unsigned HBackDef    = 48;
  localparam int unsigned VVisibleDef = 480;
  localparam int unsigned VFrontDef   = 10;
  localparam int unsigned VSyncDef    = 2;
  localparam int unsigned VBackDef    = 33;

  localparam int unsigned PadWidth    = 8;
  localparam int unsigned PadDistance = 16;
  localparam int unsigned PadHeight   = 64;
  localparam int unsigned BallSize    = 8;

  localparam logic [2:0] ColorBg   = 3'b000;
  localparam logic [2:0] ColorPad  = 3'b111;
  localparam logic [2:0] ColorBall = 3'b110;

  // 11-bit half-open span test; lo + len cannot overflow for 10-bit inputs.
  function automatic logic in_span(logic [10:0] p, logic [10:0] lo, logic [10:0] len);
    return (p >= lo) && (p < lo + len);
  endfunction

endpackage

// File: rtl/pong_video_renderer_vga_timing.sv
// Raster counters for the VGA renderer: free-running h/v position, sync decode
// and visible flag, all combinational views of the counter state.
module pong_video_renderer_vga_timing
  import pong_video_renderer_pkg::*;
#(
  parameter int unsigned HVisible = HVisibleDef,
  parameter int unsigned HFront   = HFrontDef,
  parameter int unsigned HSync    = HSyncDef,
  parameter int unsigned HBack    = HBackDef,
  parameter int unsigned VVisible = VVisibleDef,
  parameter int unsigned VFront   = VFrontDef,
  parameter int unsigned VSync    = VSyncDef,
  parameter int unsigned VBack    = VBackDef
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [9:0] hcnt_o,
  output logic [9:0] vcnt_o,
  output logic       hs_n_o,
  output logic       vs_n_o,
  output logic       visible_o
);

  localparam int unsigned HTotal = HVisible + HFront + HSync + HBack;
  localparam int unsigned VTotal = VVisible + VFront + VSync + VBack;

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == 10'(HTotal - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == 10'(VTotal - 1)) ? '0 : vcnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o    = hcnt_q;
  assign vcnt_o    = vcnt_q;
  assign hs_n_o    = !((hcnt_q >= 10'(HVisible + HFront)) &&
                       (hcnt_q < 10'(HVisible + HFront + HSync)));
  assign vs_n_o    = !((vcnt_q >= 10'(VVisible + VFront)) &&
                       (vcnt_q < 10'(VVisible + VFront + VSync)));
  assign visible_o = (hcnt_q < 10'(HVisible)) && (vcnt_q < 10'(VVisible));

endmodule

// File: rtl/pong_video_renderer.sv
// Pong VGA renderer: snapshots game state at the start of vertical blanking and
// draws two pads and a ball, with every output registered one cycle after decode.
module pong_video_renderer
  import pong_video_renderer_pkg::*;
#(
  parameter int unsigned HVisible = HVisibleDef,
  parameter int unsigned HFront   = HFrontDef,
  parameter int unsigned HSync    = HSyncDef,
  parameter int unsigned HBack    = HBackDef,
  parameter int unsigned VVisible = VVisibleDef,
  parameter int unsigned VFront   = VFrontDef,
  parameter int unsigned VSync    = VSyncDef,
  parameter int unsigned VBack    = VBackDef
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] pad_left_i,
  input  logic [9:0] pad_right_i,
  input  logic [9:0] ball_x_i,
  input  logic [8:0] ball_y_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [2:0] rgb_o,
  output logic       frame_start_o
);

  logic [9:0] hcnt, vcnt;
  logic       hs_n, vs_n, visible;

  pong_video_renderer_vga_timing #(
    .HVisible (HVisible),
    .HFront   (HFront),
    .HSync    (HSync),
    .HBack    (HBack),
    .VVisible (VVisible),
    .VFront   (VFront),
    .VSync    (VSync),
    .VBack    (VBack)
  ) u_timing (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .hcnt_o    (hcnt),
    .vcnt_o    (vcnt),
    .hs_n_o    (hs_n),
    .vs_n_o    (vs_n),
    .visible_o (visible)
  );

  logic [9:0] sp_l_q, sp_r_q, sb_x_q;
  logic [8:0] sb_y_q;
  logic       snap;
  logic       hsync_q, vsync_q, frame_start_q;
  logic [2:0] rgb_q, rgb_d;
  logic [10:0] x, y;
  logic       on_left, on_right, on_ball;

  assign snap = (hcnt == 10'd0) && (vcnt == 10'(VVisible));
  assign x    = {1'b0, hcnt};
  assign y    = {1'b0, vcnt};

  assign on_left  = in_span(x, 11'(PadDistance), 11'(PadWidth)) &&
                    in_span(y, {1'b0, sp_l_q}, 11'(PadHeight));
  assign on_right = in_span(x, 11'(HVisible - PadDistance - PadWidth), 11'(PadWidth)) &&
                    in_span(y, {1'b0, sp_r_q}, 11'(PadHeight));
  assign on_ball  = in_span(x, {1'b0, sb_x_q}, 11'(BallSize)) &&
                    in_span(y, {2'b00, sb_y_q}, 11'(BallSize));

  // Ball wins over pads; the visible gate clips anything past the raster edge.
  always_comb begin
    rgb_d = ColorBg;
    if (!visible) begin
      rgb_d = 3'b000;
    end else if (on_ball) begin
      rgb_d = ColorBall;
    end else if (on_left || on_right) begin
      rgb_d = ColorPad;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sp_l_q        <= '0;
      sp_r_q        <= '0;
      sb_x_q        <= '0;
      sb_y_q        <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= 3'b000;
      frame_start_q <= 1'b0;
    end else begin
      if (snap) begin
        sp_l_q <= pad_left_i;
        sp_r_q <= pad_right_i;
        sb_x_q <= ball_x_i;
        sb_y_q <= ball_y_i;
      end
      hsync_q       <= hs_n;
      vsync_q       <= vs_n;
      rgb_q         <= rgb_d;
      frame_start_q <= snap;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign rgb_o         = rgb_q;
  assign frame_start_o = frame_start_q;

endmodule
